// File: rtl/latency_meter_pkg.sv
// Shared widths, defaults and error-bit indices for the latency meter slice.
package latency_meter_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 1024;

    localparam int unsigned PTR_W     = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_OUT_W = PTR_W + 1;

    localparam int unsigned ERR_OVERFLOW = 0;
    localparam int unsigned ERR_TIMEOUT  = 1;
    localparam int unsigned ERR_UNEXP    = 2;
    localparam int unsigned ERR_LOST     = 3;
    localparam int unsigned ERR_W        = 4;

endpackage

// File: rtl/latency_meter_ts_fifo.sv
// Timestamp FIFO: synchronous, push and pop allowed in the same cycle, head read combinationally.
module ts_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned CNT_OUT_W = PTR_W + 1;

    logic [W-1:0]         mem_q [DEPTH];
    logic [W-1:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic [PTR_W-1:0]     wr_q, wr_d;
    logic [CNT_OUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_OUT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_OUT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_c  = mem_q[rd_q];
    assign full_c  = (cnt_q == CNT_OUT_W'(DEPTH));
    assign empty_c = (cnt_q == '0);
    assign count   = cnt_q;

endmodule

// File: rtl/latency_meter.sv
// Launch/echo latency meter: timestamps launches, matches echoes in FIFO order,
// reports per-pulse latency with min/max tracking and sticky error flags.
module latency_meter
    import latency_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   launch,
    input  logic                   echo,
    output logic                   meas_valid,
    input  logic                   meas_ready,
    output logic [CNT_W-1:0]       meas_latency,
    output logic [CNT_W-1:0]       lat_min,
    output logic [CNT_W-1:0]       lat_max,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   err_overflow,
    output logic                   err_timeout,
    output logic                   err_unexp,
    output logic                   err_lost
);

    logic [CNT_W-1:0] ts_q, ts_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] meas_latency_q, meas_latency_d;
    logic [CNT_W-1:0] lat_min_q, lat_min_d;
    logic [CNT_W-1:0] lat_max_q, lat_max_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [CNT_W-1:0] head_c;
    logic             full_c, empty_c;
    logic [CNT_W-1:0] age_c;
    logic             echo_hit_c, timeout_hit_c, push_c, pop_c;
    logic             unexp_c, overflow_c;

    ts_fifo #(
        .W     (CNT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .push    (push_c),
        .pop     (pop_c),
        .din     (ts_q),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (outstanding)
    );

    // Match/timeout arbitration: an echo beats a timeout, at most one pop per cycle.
    always_comb begin
        age_c         = ts_q - head_c;
        echo_hit_c    = echo && !clear && !empty_c;
        timeout_hit_c = !clear && !empty_c && !echo && (age_c >= CNT_W'(TIMEOUT));
        pop_c         = echo_hit_c || timeout_hit_c;
        push_c        = launch && !clear && (!full_c || echo_hit_c);
        unexp_c       = echo && !clear && empty_c;
        overflow_c    = launch && !clear && full_c && !echo_hit_c;
    end

    // Result register, min/max and sticky error flags.
    always_comb begin
        ts_d           = ts_q + CNT_W'(1);
        meas_valid_d   = meas_valid_q;
        meas_latency_d = meas_latency_q;
        lat_min_d      = lat_min_q;
        lat_max_d      = lat_max_q;
        err_d          = err_q;
        if (clear) begin
            ts_d           = '0;
            meas_valid_d   = 1'b0;
            meas_latency_d = '0;
            lat_min_d      = '1;
            lat_max_d      = '0;
            err_d          = '0;
        end else begin
            if (meas_valid_q && meas_ready) begin
                meas_valid_d = 1'b0;
            end
            if (echo_hit_c) begin
                if (meas_valid_q && !meas_ready) begin
                    err_d[ERR_LOST] = 1'b1;
                end else begin
                    meas_valid_d   = 1'b1;
                    meas_latency_d = age_c;
                end
                if (age_c < lat_min_q) begin
                    lat_min_d = age_c;
                end
                if (age_c > lat_max_q) begin
                    lat_max_d = age_c;
                end
            end
            if (timeout_hit_c) begin
                err_d[ERR_TIMEOUT] = 1'b1;
            end
            if (unexp_c) begin
                err_d[ERR_UNEXP] = 1'b1;
            end
            if (overflow_c) begin
                err_d[ERR_OVERFLOW] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q           <= '0;
            meas_valid_q   <= 1'b0;
            meas_latency_q <= '0;
            lat_min_q      <= '1;
            lat_max_q      <= '0;
            err_q          <= '0;
        end else begin
            ts_q           <= ts_d;
            meas_valid_q   <= meas_valid_d;
            meas_latency_q <= meas_latency_d;
            lat_min_q      <= lat_min_d;
            lat_max_q      <= lat_max_d;
            err_q          <= err_d;
        end
    end

    assign meas_valid   = meas_valid_q;
    assign meas_latency = meas_latency_q;
    assign lat_min      = lat_min_q;
    assign lat_max      = lat_max_q;
    assign err_overflow = err_q[ERR_OVERFLOW];
    assign err_timeout  = err_q[ERR_TIMEOUT];
    assign err_unexp    = err_q[ERR_UNEXP];
    assign err_lost     = err_q[ERR_LOST];

endmodule

// File: tb/tb_latency_meter.sv
// Scoreboard bench for latency_meter: launches via a 3-clk delay line or manual echoes.
module tb_latency_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TIMEOUT = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             launch;
    logic             echo;
    logic             echo_man;
    logic             use_dly;
    logic [2:0]       dly;
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] meas_latency;
    logic [CNT_W-1:0] lat_min;
    logic [CNT_W-1:0] lat_max;
    logic [3:0]       outstanding;
    logic             err_overflow, err_timeout, err_unexp, err_lost;

    int               n_vec = 0;
    int               n_err = 0;
    int               n_got = 0;
    int               peak  = 0;
    int unsigned      exp_q[$];

    latency_meter #(
        .CNT_W   (CNT_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .launch       (launch),
        .echo         (echo),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .meas_latency (meas_latency),
        .lat_min      (lat_min),
        .lat_max      (lat_max),
        .outstanding  (outstanding),
        .err_overflow (err_overflow),
        .err_timeout  (err_timeout),
        .err_unexp    (err_unexp),
        .err_lost     (err_lost)
    );

    always #5 clk = ~clk;

    // Link model: launch register through a 3-clk delay line back to echo.
    always @(posedge clk or posedge rst) begin
        if (rst) dly <= 3'b000;
        else     dly <= {dly[1:0], launch};
    end
    assign echo = use_dly ? dly[2] : echo_man;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    function automatic logic [31:0] errs();
        return 32'({err_lost, err_unexp, err_timeout, err_overflow});
    endfunction

    // Result monitor: every handshake pops one expected latency.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(outstanding) > peak) peak = int'(outstanding);
            if (meas_valid && meas_ready) begin
                n_got++;
                if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
                else                   check("meas_latency", 32'(meas_latency), exp_q.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int got0;
        rst = 1'b1; clear = 1'b0; launch = 1'b0; echo_man = 1'b0;
        use_dly = 1'b1; meas_ready = 1'b1;
        step(); step();
        rst = 1'b0;

        // Reset values
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_lat", 32'(meas_latency), 32'd0);
        check("rst_min", 32'(lat_min), 32'hFFFF);
        check("rst_max", 32'(lat_max), 32'd0);
        check("rst_outst", 32'(outstanding), 32'd0);
        check("rst_errs", errs(), 32'd0);

        // Single launch through the delay line
        exp_q.push_back(3);
        launch = 1'b1; step(); launch = 1'b0;
        check("t1_outst", 32'(outstanding), 32'd1);
        repeat (3) step();
        check("t1_valid", 32'(meas_valid), 32'd1);
        check("t1_lat", 32'(meas_latency), 32'd3);
        check("t1_min", 32'(lat_min), 32'd3);
        check("t1_max", 32'(lat_max), 32'd3);
        step();
        check("t1_drop", 32'(meas_valid), 32'd0);
        check("t1_errs", errs(), 32'd0);

        // Eight back-to-back launches
        do_clear();
        peak = 0; got0 = n_got;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(3);
            launch = 1'b1; step();
        end
        launch = 1'b0;
        repeat (8) step();
        check("t2_results", 32'(n_got - got0), 32'd8);
        check("t2_peak", 32'(peak), 32'd3);
        check("t2_outst", 32'(outstanding), 32'd0);
        check("t2_min", 32'(lat_min), 32'd3);
        check("t2_max", 32'(lat_max), 32'd3);
        check("t2_errs", errs(), 32'd0);

        // Overflow, then every entry times out
        use_dly = 1'b0;
        do_clear();
        for (int i = 0; i < 9; i++) begin
            launch = 1'b1; step();
        end
        launch = 1'b0;
        check("t3_full", 32'(outstanding), 32'd8);
        check("t3_errs_ovf", errs(), 32'b0001);
        repeat (1015) step();
        check("t3_pre_to", 32'(outstanding), 32'd8);
        step();
        check("t3_first_to", 32'(outstanding), 32'd7);
        repeat (20) step();
        check("t3_drain", 32'(outstanding), 32'd0);
        check("t3_errs_to", errs(), 32'b0011);
        check("t3_valid", 32'(meas_valid), 32'd0);
        check("t3_min", 32'(lat_min), 32'hFFFF);

        // Echo into an empty FIFO alongside a launch
        do_clear();
        exp_q.push_back(5);
        launch = 1'b1; echo_man = 1'b1; step();
        launch = 1'b0; echo_man = 1'b0;
        check("t4_unexp", errs(), 32'b0100);
        check("t4_outst", 32'(outstanding), 32'd1);
        repeat (4) step();
        echo_man = 1'b1; step(); echo_man = 1'b0;
        check("t4_valid", 32'(meas_valid), 32'd1);
        check("t4_lat", 32'(meas_latency), 32'd5);
        step();

        // Back-pressure: second result lost, still tracked in min/max
        do_clear();
        meas_ready = 1'b0;
        exp_q.push_back(4);
        launch = 1'b1; step();
        step();
        launch = 1'b0; step(); step();
        echo_man = 1'b1; step(); echo_man = 1'b0;
        step(); step();
        echo_man = 1'b1; step(); echo_man = 1'b0;
        check("t5_valid", 32'(meas_valid), 32'd1);
        check("t5_held", 32'(meas_latency), 32'd4);
        check("t5_errs", errs(), 32'b1000);
        check("t5_min", 32'(lat_min), 32'd4);
        check("t5_max", 32'(lat_max), 32'd6);
        meas_ready = 1'b1; step();
        check("t5_accept", 32'(meas_valid), 32'd0);

        // Timestamp wrap
        do_clear();
        repeat (32'hFFFE) step();
        exp_q.push_back(4);
        launch = 1'b1; step(); launch = 1'b0;
        repeat (3) step();
        echo_man = 1'b1; step(); echo_man = 1'b0;
        check("t6_valid", 32'(meas_valid), 32'd1);
        check("t6_wrap_lat", 32'(meas_latency), 32'd4);
        step();

        // Asynchronous reset with a pulse in flight
        use_dly = 1'b1;
        launch = 1'b1; step(); launch = 1'b0; step();
        check("t7_inflight", 32'(outstanding), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_valid", 32'(meas_valid), 32'd0);
        check("t7_rst_lat", 32'(meas_latency), 32'd0);
        check("t7_rst_min", 32'(lat_min), 32'hFFFF);
        check("t7_rst_max", 32'(lat_max), 32'd4 & 32'd0);
        check("t7_rst_outst", 32'(outstanding), 32'd0);
        step();
        rst = 1'b0;
        repeat (6) step();
        check("t7_no_result", 32'(meas_valid), 32'd0);
        check("t7_outst", 32'(outstanding), 32'd0);
        check("t7_errs", errs(), 32'd0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
